mem_port_arbiter: RTL

- Shares one single-port SRAM (1-cycle registered read) between the CortexM0 instruction-fetch port and its data port.
- Grants one request per cycle, with data priority by default and a starvation boost for fetch.
- Generates byte enables and write-lane replication from DSIZE/DADDR, and flags misaligned or reserved accesses.
- Sits between CortexM0 and the SRAM model, replacing the dual-port hookup.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_be_gen.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the CortexM0 single-port SRAM arbiter: access sizes,
// arbitration FSM states and grant owners.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } dsize_e;

  typedef enum logic [0:0] {
    ST_NORM  = 1'b0,
    ST_IPRIO = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam logic [15:0] PERF_MAX = 16'hFFFF;

  // Saturating increment used by the optional stall counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == PERF_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_be_gen.sv
// Byte-enable and write-lane replication for data-port accesses; also flags
// misaligned halfword/word accesses and the reserved size encoding.
module mem_be_gen
  import mem_arb_pkg::*;
(
  input  logic [1:0]  i_dsize,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misalign
);

  always_comb begin
    o_be       = 4'b0000;
    o_wdata    = 32'd0;
    o_misalign = 1'b0;
    case (dsize_e'(i_dsize))
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        if (i_addr_lo[0]) begin
          o_misalign = 1'b1;
        end else begin
          o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
          o_wdata = {2{i_wdata[15:0]}};
        end
      end
      SZ_WORD: begin
        if (i_addr_lo != 2'b00) begin
          o_misalign = 1'b1;
        end else begin
          o_be    = 4'b1111;
          o_wdata = i_wdata;
        end
      end
      default: o_misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between the CortexM0 fetch and data ports.
// Optional stall counters (PERF_ISTALL/PERF_DSTALL) with MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int STARVE_LIM = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IREQ,
  input  logic [31:0]       IADDR,
  output logic              IGNT,
  output logic              IVALID,
  output logic [31:0]       INSTR,
  input  logic              DREQ,
  input  logic [31:0]       DADDR,
  input  logic              DRW,
  input  logic [1:0]        DSIZE,
  input  logic [31:0]       DWDATA,
  output logic              DGNT,
  output logic              DVALID,
  output logic [31:0]       DRDATA,
  output logic              DERR,
  output logic              MCSN,
  output logic [ADDR_W-1:0] MADDR,
  output logic              MWE,
  output logic [3:0]        MBE,
  output logic [31:0]       MDI,
  input  logic [31:0]       MDO,
  output logic              DBG_STATE
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [15:0]       PERF_ISTALL,
  output logic [15:0]       PERF_DSTALL
`endif
);

  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  // Handshake: a request is held until its GNT; GNT is combinational, and the
  // matching VALID (plus DERR for data) follows exactly one cycle later.
  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic [CW-1:0] r_starve;
  logic [CW-1:0] w_starve_nxt;
  owner_e        r_tag;
  owner_e        w_owner;
  logic          r_derr;

  logic [3:0]    w_be;
  logic [31:0]   w_mdi;
  logic          w_misalign;
  logic          w_unused;

  mem_be_gen u_be_gen (
    .i_dsize    (DSIZE),
    .i_addr_lo  (DADDR[1:0]),
    .i_wdata    (DWDATA),
    .o_be       (w_be),
    .o_wdata    (w_mdi),
    .o_misalign (w_misalign)
  );

  always_comb begin
    w_owner = OWN_NONE;
    if (!RESET) begin
      if (r_state == ST_IPRIO) begin
        if (IREQ)      w_owner = OWN_I;
        else if (DREQ) w_owner = OWN_D;
      end else begin
        if (DREQ)      w_owner = OWN_D;
        else if (IREQ) w_owner = OWN_I;
      end
    end
  end

  assign IGNT = (w_owner == OWN_I);
  assign DGNT = (w_owner == OWN_D);

  // Illegal data accesses still take the grant but leave the SRAM deselected.
  always_comb begin
    MCSN  = 1'b1;
    MWE   = 1'b0;
    MBE   = 4'b0000;
    MADDR = '0;
    MDI   = 32'd0;
    case (w_owner)
      OWN_I: begin
        MCSN  = 1'b0;
        MBE   = 4'b1111;
        MADDR = IADDR[ADDR_W+1:2];
      end
      OWN_D: begin
        if (!w_misalign) begin
          MCSN  = 1'b0;
          MWE   = DRW;
          MBE   = w_be;
          MADDR = DADDR[ADDR_W+1:2];
          MDI   = w_mdi;
        end
      end
      default: ;
    endcase
  end

  // Starvation tracking counts consecutive denied fetch cycles only.
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    if (IGNT) begin
      w_state_nxt  = ST_NORM;
      w_starve_nxt = '0;
    end else if (!IREQ) begin
      w_state_nxt  = ST_NORM;
      w_starve_nxt = '0;
    end else if (r_state == ST_NORM) begin
      if (r_starve != LIM) w_starve_nxt = r_starve + 1'b1;
      if (w_starve_nxt == LIM) w_state_nxt = ST_IPRIO;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= ST_NORM;
      r_starve <= '0;
      r_tag    <= OWN_NONE;
      r_derr   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_tag    <= w_owner;
      r_derr   <= DGNT & w_misalign;
    end
  end

  // Gating with RESET drops a completion that was in flight when reset hit.
  assign IVALID    = (r_tag == OWN_I) & ~RESET;
  assign DVALID    = (r_tag == OWN_D) & ~RESET;
  assign DERR      = r_derr & ~RESET;
  assign INSTR     = MDO;
  assign DRDATA    = MDO;
  assign DBG_STATE = r_state;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [15:0] r_perf_i;
  logic [15:0] r_perf_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_perf_i <= 16'd0;
      r_perf_d <= 16'd0;
    end else begin
      if (IREQ && !IGNT) r_perf_i <= sat_inc16(r_perf_i);
      if (DREQ && !DGNT) r_perf_d <= sat_inc16(r_perf_d);
    end
  end

  assign PERF_ISTALL = r_perf_i;
  assign PERF_DSTALL = r_perf_d;
`endif

  assign w_unused = ^{IADDR[31:ADDR_W+2], IADDR[1:0], DADDR[31:ADDR_W+2]};

endmodule
